// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART receive and transmit paths.
//   state_e          : receiver FSM state encoding (3 bits)
//   DATA_BITS        : payload bits per frame (8N1)
//   DEFAULT_BAUD_DIV : clk cycles per bit, 1 MHz / 9600; also used by the transmitter
package uart_pkg;

    localparam int DATA_BITS        = 8;
    localparam int DEFAULT_BAUD_DIV = 104;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_e;

endpackage : uart_pkg

// File: rtl/uart_rx_if.sv
// uart_rx_if
// Bundles the serial line and the received-byte outputs of the UART receiver.
//   rx         : asynchronous serial line, idle high (driven by master)
//   data_out   : last correctly received byte, LSB received first
//   data_valid : one-cycle strobe, data_out updated in the same cycle
//   frame_err  : one-cycle strobe when the stop bit samples low
//   busy       : high from start-bit detection until the receiver is idle again
// Modports:
//   master : line driver / byte consumer
//   slave  : the receiver
interface uart_rx_if;
    import uart_pkg::*;

    logic                 rx;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 frame_err;
    logic                 busy;

    modport master (
        output rx,
        input  data_out,
        input  data_valid,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  rx,
        output data_out,
        output data_valid,
        output frame_err,
        output busy
    );

endinterface : uart_rx_if

// File: rtl/sync_ff.sv
// sync_ff
// Multi-flop synchronizer for a single asynchronous input. Reset value is
// configurable so that idle-high lines come out of reset looking idle.
//   clk   : system clock
//   rst_n : synchronous reset, active low
//   d_i   : asynchronous input
//   q_o   : synchronized output, SYNC_STAGES cycles behind d_i
module sync_ff #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule : sync_ff

// File: rtl/uart_rx.sv
// uart_rx
// 8N1 UART receiver. The serial line is synchronized, the start bit is
// qualified at its midpoint, and every following bit is sampled one bit
// period later, i.e. at mid-bit. A good frame produces a one-cycle
// data_valid strobe with data_out updated in the same cycle; a low stop bit
// produces a one-cycle frame_err strobe and the receiver then waits for the
// line to return high before looking for another start bit.
//   clk   : system clock
//   rst_n : synchronous reset, active low
//   bus   : uart_rx_if.slave (rx in; data_out, data_valid, frame_err, busy out)
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV    = DEFAULT_BAUD_DIV,
    parameter int SYNC_STAGES = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    uart_rx_if.slave bus
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

    logic                 rx_s;

    state_e               state_q,  state_d;
    logic [CNT_W-1:0]     cnt_q,    cnt_d;
    logic [BIT_W-1:0]     bit_q,    bit_d;
    logic [DATA_BITS-1:0] shift_q,  shift_d;
    logic [DATA_BITS-1:0] data_q,   data_d;
    logic                 valid_q,  valid_d;
    logic                 ferr_q,   ferr_d;

    // Synchronizer resets to 1 so the line looks idle straight out of reset.
    sync_ff #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (bus.rx),
        .q_o   (rx_s)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // The shift register is pure payload; a partial byte left in it after
    // reset is never published because every frame rewrites all bits first.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Counters parked at zero while idle.
                cnt_d = '0;
                bit_d = '0;
                if (!rx_s) begin
                    // Half a bit period lands the next sample mid start bit.
                    cnt_d   = HALF_LOAD;
                    state_d = ST_START;
                end
            end

            ST_START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (rx_s) begin
                    // Line back high by mid start bit: a glitch, not a frame.
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = FULL_LOAD;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end
            end

            ST_DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    shift_d[bit_q] = rx_s;
                    cnt_d          = FULL_LOAD;
                    if (bit_q == LAST_BIT) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end

            ST_STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // Leave at mid stop bit so a start bit that follows
                    // immediately is still caught from IDLE.
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end
            end

            ST_BREAK: begin
                // A held-low line must not be re-read as a stream of frames.
                cnt_d = '0;
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                bit_d   = '0;
            end
        endcase
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.frame_err  = ferr_q;
    assign bus.busy       = (state_q != ST_IDLE);

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// tb_uart_rx
// Directed bench for uart_rx at BAUD_DIV=104, SYNC_STAGES=2. A transmitter
// model drives the serial line; a monitor on the falling clock edge records
// strobes and received bytes, and the main sequence compares them against
// hand-computed values.
module tb_uart_rx;

    localparam int BAUD = 104;

    logic clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    // Monitor state
    int          cyc     = 0;
    int          nvalid  = 0;
    int          nferr   = 0;
    int          nboth   = 0;
    int          nbusy   = 0;
    logic [7:0]  hist[$];
    int          vcyc[$];

    uart_rx_if u_if ();

    uart_rx #(
        .BAUD_DIV    (BAUD),
        .SYNC_STAGES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (u_if.data_valid === 1'b1) begin
            nvalid <= nvalid + 1;
            hist.push_back(u_if.data_out);
            vcyc.push_back(cyc);
        end
        if (u_if.frame_err === 1'b1) nferr <= nferr + 1;
        if (u_if.data_valid === 1'b1 && u_if.frame_err === 1'b1) nboth <= nboth + 1;
        if (u_if.busy === 1'b1) nbusy <= nbusy + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        u_if.rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // One 8N1 frame; line is left at the stop-bit level.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int period);
        u_if.rx = 1'b0;
        repeat (period) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            u_if.rx = b[i];
            repeat (period) @(negedge clk);
        end
        u_if.rx = stop;
        repeat (period) @(negedge clk);
    endtask

    int v0, f0, b0, t0, lat;

    initial begin
        u_if.rx = 1'b1;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_data_out",   32'(u_if.data_out),   32'h00);
        check("rst_data_valid", 32'(u_if.data_valid), 32'h0);
        check("rst_frame_err",  32'(u_if.frame_err),  32'h0);
        check("rst_busy",       32'(u_if.busy),       32'h0);
        rst_n = 1'b1;
        idle(10);

        // Single frame 0x55 with latency
        v0 = nvalid; f0 = nferr;
        t0 = cyc;
        send_frame(8'h55, 1'b1, BAUD);
        idle(20);
        check("b55_count",  32'(nvalid - v0), 32'd1);
        check("b55_data",   32'(hist[v0]),    32'h55);
        check("b55_ferr",   32'(nferr - f0),  32'd0);
        check("b55_busy",   32'(u_if.busy),   32'h0);
        lat = vcyc[v0] - t0;
        check("b55_latency", 32'(lat >= 988 && lat <= 993), 32'd1);

        // Back-to-back 0x78, 0xC8
        v0 = nvalid; f0 = nferr;
        send_frame(8'h78, 1'b1, BAUD);
        send_frame(8'hC8, 1'b1, BAUD);
        idle(20);
        check("b2b_count", 32'(nvalid - v0), 32'd2);
        check("b2b_data0", 32'(hist[v0]),    32'h78);
        check("b2b_data1", 32'(hist[v0+1]),  32'hC8);
        check("b2b_gap",   32'(vcyc[v0+1] - vcyc[v0]), 32'd1040);
        check("b2b_ferr",  32'(nferr - f0),  32'd0);

        // Glitch: 20 low cycles
        v0 = nvalid; f0 = nferr; b0 = nbusy;
        u_if.rx = 1'b0;
        repeat (20) @(negedge clk);
        idle(100);
        check("glitch_valid", 32'(nvalid - v0), 32'd0);
        check("glitch_ferr",  32'(nferr - f0),  32'd0);
        check("glitch_busy_len", 32'((nbusy - b0) >= 50 && (nbusy - b0) <= 54), 32'd1);
        check("glitch_busy_end", 32'(u_if.busy), 32'h0);

        // Framing error on 0xA5, then line held low
        v0 = nvalid; f0 = nferr;
        send_frame(8'hA5, 1'b0, BAUD);
        repeat (300) @(negedge clk);
        check("ferr_held_busy", 32'(u_if.busy), 32'h1);
        idle(50);
        check("ferr_count",   32'(nferr - f0),   32'd1);
        check("ferr_novalid", 32'(nvalid - v0),  32'd0);
        check("ferr_hold",    32'(u_if.data_out), 32'hC8);
        check("ferr_idle",    32'(u_if.busy),    32'h0);
        send_frame(8'h3C, 1'b1, BAUD);
        idle(20);
        check("after_ferr_count", 32'(nvalid - v0), 32'd1);
        check("after_ferr_data",  32'(hist[v0]),    32'h3C);
        check("after_ferr_nferr", 32'(nferr - f0),  32'd1);

        // Reset during data bit 4 of 0x5A
        v0 = nvalid; f0 = nferr;
        u_if.rx = 1'b0;
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            u_if.rx = 1'(8'h5A >> i);
            repeat (BAUD) @(negedge clk);
        end
        u_if.rx = 1'b1;          // bit 4 of 0x5A
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_rst_data",  32'(u_if.data_out),   32'h00);
        check("mid_rst_busy",  32'(u_if.busy),       32'h0);
        check("mid_rst_valid", 32'(u_if.data_valid), 32'h0);
        rst_n = 1'b1;
        idle(200);
        check("mid_rst_nostrobe", 32'(nvalid - v0), 32'd0);
        send_frame(8'h81, 1'b1, BAUD);
        idle(20);
        check("post_rst_count", 32'(nvalid - v0), 32'd1);
        check("post_rst_data",  32'(hist[v0]),    32'h81);
        check("post_rst_ferr",  32'(nferr - f0),  32'd0);

        // Baud tolerance: -3% and +3% bit periods
        v0 = nvalid; f0 = nferr;
        send_frame(8'h00, 1'b1, 101);
        send_frame(8'hFF, 1'b1, 101);
        send_frame(8'h55, 1'b1, 101);
        send_frame(8'h00, 1'b1, 107);
        send_frame(8'hFF, 1'b1, 107);
        send_frame(8'h55, 1'b1, 107);
        idle(20);
        check("tol_count", 32'(nvalid - v0), 32'd6);
        check("tol_fast_00", 32'(hist[v0]),   32'h00);
        check("tol_fast_ff", 32'(hist[v0+1]), 32'hFF);
        check("tol_fast_55", 32'(hist[v0+2]), 32'h55);
        check("tol_slow_00", 32'(hist[v0+3]), 32'h00);
        check("tol_slow_ff", 32'(hist[v0+4]), 32'hFF);
        check("tol_slow_55", 32'(hist[v0+5]), 32'h55);
        check("tol_ferr",  32'(nferr - f0),  32'd0);

        // Strobes never coincide
        check("no_dual_strobe", 32'(nboth), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_uart_rx
